// File: rtl/fft_reorder_buffer_if.sv
// Sample bus around the FFT reorder buffer: scrambled-address write stream
// from the FFT on one side, natural-order valid/ready stream on the other.
//   frame_len  : points in the frame being written (0 means 2**ADDR_W)
//   di_*       : FFT sample, its natural-order index and write strobe
//   out_ready  : downstream accepts the current output sample
//   do_*       : reordered sample, its index, valid and end-of-frame flag
// master = the FFT/back-end side, slave = the reorder buffer.
interface fft_reorder_buffer_if #(
    parameter int unsigned WIDTH  = 18,
    parameter int unsigned ADDR_W = 11
);
    logic [ADDR_W-1:0] frame_len;
    logic [WIDTH-1:0]  di_re;
    logic [WIDTH-1:0]  di_im;
    logic              di_en;
    logic [ADDR_W-1:0] di_addr;
    logic              out_ready;
    logic [WIDTH-1:0]  do_re;
    logic [WIDTH-1:0]  do_im;
    logic              do_valid;
    logic [ADDR_W-1:0] do_index;
    logic              do_last;

    modport master (
        output frame_len, di_re, di_im, di_en, di_addr, out_ready,
        input  do_re, do_im, do_valid, do_index, do_last
    );

    modport slave (
        input  frame_len, di_re, di_im, di_en, di_addr, out_ready,
        output do_re, do_im, do_valid, do_index, do_last
    );
endinterface

// File: rtl/fft_reorder_buffer.sv
// Ping-pong reorder buffer behind the mixed-radix FFT. Samples are written
// at the index the FFT supplies; a completed bank is streamed out in natural
// order 0..len-1 while the other bank fills.
//   clk      : system clock, rising edge
//   rst      : asynchronous active-low reset
//   bus      : fft_reorder_buffer_if.slave (write stream in, ordered stream out)
//   busy     : a bank is filling or full, or a drain is in progress
//   overflow : sticky, a write was dropped because the write bank was full
module fft_reorder_buffer #(
    parameter int unsigned WIDTH  = 18,
    parameter int unsigned ADDR_W = 11
) (
    input  logic                 clk,
    input  logic                 rst,
    fft_reorder_buffer_if.slave  bus,
    output logic                 busy,
    output logic                 overflow
);
    localparam int unsigned DEPTH  = 2 ** ADDR_W;
    localparam int unsigned CNT_W  = ADDR_W + 1;
    localparam int unsigned WORD_W = 2 * WIDTH;

    typedef enum logic [1:0] {IDLE, PRIME, STREAM} state_t;

    // Both banks in one array, bank select is the address MSB.
    logic [WORD_W-1:0] mem [2*DEPTH];

    state_t            state, state_n;
    logic              wbank, rbank;
    logic [1:0]        full, full_n;
    logic [CNT_W-1:0]  wcnt, wcnt_n;
    logic [CNT_W-1:0]  len [2];

    logic [CNT_W-1:0]  frame_len_eff;
    logic [CNT_W-1:0]  len_cur;
    logic [CNT_W-1:0]  wcnt_inc;
    logic [CNT_W-1:0]  rlen_m1;
    logic              wr_acc, wr_drop, wr_done;
    logic              xfer, last_xfer;
    logic              rd_en;
    logic [ADDR_W-1:0] raddr;
    logic [ADDR_W-1:0] index_n;
    logic              valid_n, last_n;
    logic              busy_n;

    // Write side: accept into the current bank unless it is still waiting to drain.
    always_comb begin
        frame_len_eff = (bus.frame_len == '0) ? CNT_W'(DEPTH) : CNT_W'(bus.frame_len);
        wr_acc        = bus.di_en & ~full[wbank];
        wr_drop       = bus.di_en &  full[wbank];
        // The first write of a frame uses the incoming length, it is not latched yet.
        len_cur       = (wcnt == '0) ? frame_len_eff : len[wbank];
        wcnt_inc      = wcnt + CNT_W'(1);
        wr_done       = wr_acc && (wcnt_inc == len_cur);
        wcnt_n        = wcnt;
        if (wr_done) begin
            wcnt_n = '0;
        end else if (wr_acc) begin
            wcnt_n = wcnt_inc;
        end
    end

    // Read FSM next state and next output-register values.
    always_comb begin
        state_n   = state;
        valid_n   = bus.do_valid;
        index_n   = bus.do_index;
        last_n    = bus.do_last;
        raddr     = bus.do_index;
        rd_en     = 1'b0;
        last_xfer = 1'b0;
        xfer      = bus.do_valid & bus.out_ready;
        rlen_m1   = len[rbank] - CNT_W'(1);
        case (state)
            IDLE: begin
                if (full[rbank]) begin
                    rd_en   = 1'b1;
                    raddr   = '0;
                    state_n = PRIME;
                end
            end
            PRIME: begin
                rd_en   = 1'b1;
                raddr   = '0;
                valid_n = 1'b1;
                index_n = '0;
                last_n  = (rlen_m1 == '0);
                state_n = STREAM;
            end
            STREAM: begin
                // Reload every cycle; on a stall the same address is re-read.
                rd_en = 1'b1;
                if (xfer) begin
                    if (bus.do_last) begin
                        last_xfer = 1'b1;
                        valid_n   = 1'b0;
                        last_n    = 1'b0;
                        index_n   = '0;
                        state_n   = IDLE;
                    end else begin
                        raddr   = bus.do_index + ADDR_W'(1);
                        index_n = raddr;
                        last_n  = (CNT_W'(raddr) == rlen_m1);
                    end
                end
            end
            default: state_n = IDLE;
        endcase
    end

    // Bank flags: completion and drain never target the same bank on one edge.
    always_comb begin
        full_n = full;
        if (wr_done) begin
            full_n[wbank] = 1'b1;
        end
        if (last_xfer) begin
            full_n[rbank] = 1'b0;
        end
        busy_n = (|full_n) | (wcnt_n != '0) | (state_n != IDLE);
    end

    // FSM state register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    // Pointers, flags, counters and output registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wbank        <= 1'b0;
            rbank        <= 1'b0;
            full         <= '0;
            wcnt         <= '0;
            len[0]       <= '0;
            len[1]       <= '0;
            overflow     <= 1'b0;
            busy         <= 1'b0;
            bus.do_valid <= 1'b0;
            bus.do_index <= '0;
            bus.do_last  <= 1'b0;
            bus.do_re    <= '0;
            bus.do_im    <= '0;
        end else begin
            full         <= full_n;
            wcnt         <= wcnt_n;
            busy         <= busy_n;
            bus.do_valid <= valid_n;
            bus.do_index <= index_n;
            bus.do_last  <= last_n;
            if (wr_acc && (wcnt == '0)) begin
                len[wbank] <= frame_len_eff;
            end
            if (wr_done) begin
                wbank <= ~wbank;
            end
            if (last_xfer) begin
                rbank <= ~rbank;
            end
            if (wr_drop) begin
                overflow <= 1'b1;
            end
            if (rd_en) begin
                {bus.do_re, bus.do_im} <= mem[{rbank, raddr}];
            end
        end
    end

    // Sample storage, not reset.
    always_ff @(posedge clk) begin
        if (wr_acc) begin
            mem[{wbank, bus.di_addr}] <= {bus.di_re, bus.di_im};
        end
    end
endmodule
